jtag_reg_access_ctrl: RTL and testbench

- Sequences JTAG-initiated register reads and writes into the system clock domain.
- Sits between the JTAG TAP/test-interface outputs (capture_dr, update_dr, extest_sel, tcr, trcal_out) and the on-chip register bank.
- Converts DR capture/update events into a single req/ack bus transaction. Drives the JTAG shift-register parallel load value (trcal_in) with the read data.
- Handles ack timeout, dropped-event overrun and the fixed debug pattern address.

---
 rtl/jtag_reg_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_jtag_reg_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_reg_access_ctrl.sv
// ============================================================================
// jtag_reg_access_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//    Moves JTAG-initiated register reads and writes into the system clock
//    domain. Capture-DR and Update-DR events from the TAP arrive in the tck
//    domain. Each one is synchronized into clk and turned into a single
//    req/ack transaction on the on-chip register bus. Read data is returned
//    on trcal_in_o, which is the parallel load value of the JTAG shift
//    register. One address (DEBUG_ADDR) is answered locally with a fixed
//    pattern, so the JTAG path can be checked without touching the bus.
//
// Ports:
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    capture_dr_i  TAP capture_dr (tck domain)
//    update_dr_i   TAP update_dr (tck domain)
//    extest_sel_i  EXTEST instruction selected (tck domain)
//    tcr_i         control register: [CONRLEN-1 -: 8] address, [CONRLEN-9] write
//    trcal_out_i   data shifted in over JTAG, used as write data
//    trcal_in_o    parallel load value for the JTAG shift register
//    reg_req_o     bus request, held until ack or timeout
//    reg_we_o      1 = write, 0 = read
//    reg_addr_o    bus address
//    reg_wdata_o   bus write data
//    reg_rdata_i   bus read data, valid with reg_ack_i
//    reg_ack_i     single-cycle completion strobe
//    busy_o        transaction in flight (request or turnaround cycle)
//    timeout_o     sticky: a request expired without ack
//    overrun_o     sticky: a JTAG event was dropped
//    clr_flags_i   synchronous clear of timeout_o and overrun_o
// ============================================================================
`timescale 1ns/1ps

module jtag_reg_access_ctrl #(
   parameter int         CONRLEN     = 32,
   parameter int         TRCAL_SIZE  = 32,
   parameter int         ACK_TIMEOUT = 255,
   parameter logic [7:0] DEBUG_ADDR  = 8'h0F
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  capture_dr_i,
   input  logic                  update_dr_i,
   input  logic                  extest_sel_i,
   input  logic [CONRLEN-1:0]    tcr_i,
   input  logic [TRCAL_SIZE-1:0] trcal_out_i,
   output logic [TRCAL_SIZE-1:0] trcal_in_o,
   output logic                  reg_req_o,
   output logic                  reg_we_o,
   output logic [7:0]            reg_addr_o,
   output logic [TRCAL_SIZE-1:0] reg_wdata_o,
   input  logic [TRCAL_SIZE-1:0] reg_rdata_i,
   input  logic                  reg_ack_i,
   output logic                  busy_o,
   output logic                  timeout_o,
   output logic                  overrun_o,
   input  logic                  clr_flags_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_REQ = 2'd1,
      WR_REQ = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [31:0] DEBUG_WORD   = 32'hDEAD_BEEF;
   localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

   // Synchronizer stages plus one history flop per strobe for edge detection
   logic cap_s1, cap_s2, cap_d;
   logic upd_s1, upd_s2, upd_d;
   logic ext_s1, ext_s2;

   logic cap_valid;
   logic upd_valid;

   logic [7:0] tcr_addr;
   logic       tcr_wr;
   logic       unused_tcr;

   logic [TRCAL_SIZE-1:0] debug_pattern;

   state_t                state, state_nxt;
   logic [15:0]           cnt, cnt_nxt;
   logic [TRCAL_SIZE-1:0] trcal_nxt;
   logic [7:0]            addr_nxt;
   logic                  we_nxt;
   logic [TRCAL_SIZE-1:0] wdata_nxt;
   logic                  timeout_set;
   logic                  overrun_set;

   // The three TAP signals come from the tck domain. Each one gets a plain
   // two-flop synchronizer. The third flop on capture/update holds the
   // previous synchronized value, so a rising edge shows up as a one-cycle
   // strobe. An input that rises just before edge 1 is seen in s1 after
   // edge 1 and in s2 after edge 2, and the FSM acts on it at edge 3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_s1 <= 1'b0;
         cap_s2 <= 1'b0;
         cap_d  <= 1'b0;
         upd_s1 <= 1'b0;
         upd_s2 <= 1'b0;
         upd_d  <= 1'b0;
         ext_s1 <= 1'b0;
         ext_s2 <= 1'b0;
      end else begin
         cap_s1 <= capture_dr_i;
         cap_s2 <= cap_s1;
         cap_d  <= cap_s2;
         upd_s1 <= update_dr_i;
         upd_s2 <= upd_s1;
         upd_d  <= upd_s2;
         ext_s1 <= extest_sel_i;
         ext_s2 <= ext_s1;
      end
   end

   // Events count only while EXTEST is selected. Otherwise the TAP is busy
   // with some other instruction, and its DR traffic is not meant for us.
   assign cap_valid = cap_s2 & ~cap_d & ext_s2;
   assign upd_valid = upd_s2 & ~upd_d & ext_s2;

   // tcr_i is quasi-static around Update-DR, so it is sampled directly
   // without a synchronizer. Only the address byte and write bit are used.
   assign tcr_addr = tcr_i[CONRLEN-1 -: 8];
   assign tcr_wr   = tcr_i[CONRLEN-9];

   generate
      if (CONRLEN > 9) begin : g_tcr_spare
         assign unused_tcr = ^tcr_i[CONRLEN-10:0];
      end else begin : g_tcr_none
         assign unused_tcr = 1'b0;
      end
   endgenerate

   // The debug answer is 32'hDEAD_BEEF repeated from bit 0 upward.
   // This truncates it for narrow data paths and tiles it for wide ones.
   always_comb begin
      debug_pattern = '0;
      for (int i = 0; i < TRCAL_SIZE; i++) begin
         debug_pattern[i] = DEBUG_WORD[i[4:0]];
      end
   end

   // Next-state logic for the transaction FSM.
   // In IDLE, events are decoded. If capture and update arrive together,
   // update wins and the capture is reported as dropped.
   // In the request states, the FSM waits for ack or counts toward the
   // timeout. An ack in the expiry cycle still counts as success.
   // DONE gives one cycle of bus turnaround.
   // Any event outside IDLE is dropped and flagged.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      trcal_nxt   = trcal_in_o;
      addr_nxt    = reg_addr_o;
      we_nxt      = reg_we_o;
      wdata_nxt   = reg_wdata_o;
      timeout_set = 1'b0;
      overrun_set = 1'b0;

      case (state)
         IDLE: begin
            if (upd_valid) begin
               if (cap_valid) begin
                  overrun_set = 1'b1;
               end
               if (tcr_wr && (tcr_addr != DEBUG_ADDR)) begin
                  state_nxt = WR_REQ;
                  addr_nxt  = tcr_addr;
                  wdata_nxt = trcal_out_i;
                  we_nxt    = 1'b1;
                  cnt_nxt   = '0;
               end
            end else if (cap_valid) begin
               if (tcr_addr == DEBUG_ADDR) begin
                  trcal_nxt = debug_pattern;
               end else begin
                  state_nxt = RD_REQ;
                  addr_nxt  = tcr_addr;
                  we_nxt    = 1'b0;
                  cnt_nxt   = '0;
               end
            end
         end

         RD_REQ, WR_REQ: begin
            if (cap_valid || upd_valid) begin
               overrun_set = 1'b1;
            end
            if (reg_ack_i) begin
               if (state == RD_REQ) begin
                  trcal_nxt = reg_rdata_i;
               end
               state_nxt = DONE;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_set = 1'b1;
               if (state == RD_REQ) begin
                  trcal_nxt = '0;
               end
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end

         DONE: begin
            if (cap_valid || upd_valid) begin
               overrun_set = 1'b1;
            end
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register and the held bus fields.
   // Address, write data and we only change when a transaction starts.
   // That keeps them stable for the whole request phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         trcal_in_o  <= '0;
         reg_addr_o  <= '0;
         reg_we_o    <= 1'b0;
         reg_wdata_o <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         trcal_in_o  <= trcal_nxt;
         reg_addr_o  <= addr_nxt;
         reg_we_o    <= we_nxt;
         reg_wdata_o <= wdata_nxt;
      end
   end

   // Sticky status flags. A set in the same cycle as a clear wins, so an
   // event is never lost to a badly timed clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_o <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         if (timeout_set) begin
            timeout_o <= 1'b1;
         end else if (clr_flags_i) begin
            timeout_o <= 1'b0;
         end
         if (overrun_set) begin
            overrun_o <= 1'b1;
         end else if (clr_flags_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

   assign reg_req_o = (state == RD_REQ) || (state == WR_REQ);
   assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_jtag_reg_access_ctrl.sv
// ============================================================================
// tb_jtag_reg_access_ctrl
// ----------------------------------------------------------------------------
// Directed bench for jtag_reg_access_ctrl, built with ACK_TIMEOUT = 8.
// TAP strobes are driven at the falling clk edge and held for several
// clk cycles, which imitates a slow tck. Outputs are sampled at the falling
// edge. Each scenario task carries its own expected values.
// ============================================================================
`timescale 1ns/1ps

module tb_jtag_reg_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        capture_dr;
   logic        update_dr;
   logic        extest_sel;
   logic [31:0] tcr;
   logic [31:0] trcal_out;
   logic [31:0] trcal_in;
   logic        reg_req;
   logic        reg_we;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic        busy;
   logic        timeout;
   logic        overrun;
   logic        clr_flags;

   int n_checks;
   int n_fail;

   jtag_reg_access_ctrl #(
      .CONRLEN     (32),
      .TRCAL_SIZE  (32),
      .ACK_TIMEOUT (8),
      .DEBUG_ADDR  (8'h0F)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .capture_dr_i (capture_dr),
      .update_dr_i  (update_dr),
      .extest_sel_i (extest_sel),
      .tcr_i        (tcr),
      .trcal_out_i  (trcal_out),
      .trcal_in_o   (trcal_in),
      .reg_req_o    (reg_req),
      .reg_we_o     (reg_we),
      .reg_addr_o   (reg_addr),
      .reg_wdata_o  (reg_wdata),
      .reg_rdata_i  (reg_rdata),
      .reg_ack_i    (reg_ack),
      .busy_o       (busy),
      .timeout_o    (timeout),
      .overrun_o    (overrun),
      .clr_flags_i  (clr_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits up to 12 falling edges for reg_req to rise
   task automatic wait_req(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (reg_req) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Counts the falling edges, out of the next n, that show req or busy high
   task automatic watch_activity(input int n, output int active);
      active = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (reg_req || busy) active++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++; if (reg_req !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_req got %b exp 0", reg_req); end
      n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (trcal_in !== 32'h0)  begin n_fail++; $display("[TB] FAIL reset_trcal got %h exp 0", trcal_in); end
      n_checks++; if (reg_addr !== 8'h0)   begin n_fail++; $display("[TB] FAIL reset_addr got %h exp 0", reg_addr); end
      n_checks++; if ({reg_we, timeout, overrun} !== 3'b000)
         begin n_fail++; $display("[TB] FAIL reset_flags got %b exp 000", {reg_we, timeout, overrun}); end
      @(negedge clk);
      rst_n = 1'b1;
      extest_sel = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_read();
      bit seen;
      tcr = 32'h0200_0000;
      capture_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL read_req got 0 exp 1"); end
      n_checks++; if (reg_addr !== 8'h02) begin n_fail++; $display("[TB] FAIL read_addr got %h exp 02", reg_addr); end
      n_checks++; if (reg_we !== 1'b0)    begin n_fail++; $display("[TB] FAIL read_we got %b exp 0", reg_we); end
      n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("[TB] FAIL read_busy got %b exp 1", busy); end
      repeat (2) @(negedge clk);
      n_checks++; if (reg_req !== 1'b1)   begin n_fail++; $display("[TB] FAIL read_req_hold got %b exp 1", reg_req); end
      @(negedge clk);
      reg_rdata = 32'h1234_5678;
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      n_checks++; if (trcal_in !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL read_data got %h exp 12345678", trcal_in); end
      n_checks++; if (reg_req !== 1'b0)   begin n_fail++; $display("[TB] FAIL read_req_drop got %b exp 0", reg_req); end
      n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("[TB] FAIL read_done_busy got %b exp 1", busy); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL read_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_write();
      bit seen;
      int active;
      tcr = 32'h0580_0000;
      trcal_out = 32'hCAFE_F00D;
      update_dr = 1'b1;
      wait_req(seen);
      update_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL write_req got 0 exp 1"); end
      n_checks++; if (reg_addr !== 8'h05) begin n_fail++; $display("[TB] FAIL write_addr got %h exp 05", reg_addr); end
      n_checks++; if (reg_we !== 1'b1)    begin n_fail++; $display("[TB] FAIL write_we got %b exp 1", reg_we); end
      n_checks++; if (reg_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL write_wdata got %h exp cafef00d", reg_wdata); end
      trcal_out = 32'h0;
      @(negedge clk);
      n_checks++; if (reg_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL write_wdata_hold got %h exp cafef00d", reg_wdata); end
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      n_checks++; if (reg_req !== 1'b0) begin n_fail++; $display("[TB] FAIL write_req_drop got %b exp 0", reg_req); end
      n_checks++; if (trcal_in !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL write_trcal_keep got %h exp 12345678", trcal_in); end
      repeat (2) @(negedge clk);
      tcr = 32'h0500_0000;
      update_dr = 1'b1;
      watch_activity(10, active);
      update_dr = 1'b0;
      n_checks++; if (active !== 0) begin n_fail++; $display("[TB] FAIL write_wr0_ignored got %0d active exp 0", active); end
   endtask

   task automatic test_debug();
      int active;
      tcr = 32'h0F00_0000;
      capture_dr = 1'b1;
      watch_activity(10, active);
      capture_dr = 1'b0;
      n_checks++; if (active !== 0) begin n_fail++; $display("[TB] FAIL debug_no_bus got %0d active exp 0", active); end
      n_checks++; if (trcal_in !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL debug_pattern got %h exp deadbeef", trcal_in); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_overrun();
      bit seen;
      int active;
      tcr = 32'h0200_0000;
      capture_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL overrun_req got 0 exp 1"); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL overrun_pre got %b exp 0", overrun); end
      @(negedge clk);
      capture_dr = 1'b1;
      repeat (4) @(negedge clk);
      reg_rdata = 32'hA5A5_5A5A;
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      capture_dr = 1'b0;
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_set got %b exp 1", overrun); end
      n_checks++; if (trcal_in !== 32'hA5A5_5A5A) begin n_fail++; $display("[TB] FAIL overrun_data got %h exp a5a55a5a", trcal_in); end
      @(negedge clk);
      watch_activity(10, active);
      n_checks++; if (active !== 0) begin n_fail++; $display("[TB] FAIL overrun_single_txn got %0d active exp 0", active); end
   endtask

   task automatic test_timeout();
      bit seen;
      int high;
      tcr = 32'h0300_0000;
      capture_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      high = seen ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (reg_req) high++;
         else break;
      end
      n_checks++; if (high !== 8) begin n_fail++; $display("[TB] FAIL timeout_req_cycles got %0d exp 8", high); end
      n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_flag got %b exp 1", timeout); end
      n_checks++; if (trcal_in !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_data got %h exp 0", trcal_in); end
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_clear got %b exp 0", timeout); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL overrun_clear got %b exp 0", overrun); end
   endtask

   task automatic test_extest_off();
      int active;
      extest_sel = 1'b0;
      repeat (3) @(negedge clk);
      tcr = 32'h0200_0000;
      capture_dr = 1'b1;
      watch_activity(10, active);
      capture_dr = 1'b0;
      n_checks++; if (active !== 0) begin n_fail++; $display("[TB] FAIL extest_off_no_bus got %0d active exp 0", active); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL extest_off_overrun got %b exp 0", overrun); end
      extest_sel = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_collision();
      bit seen;
      tcr = 32'h0680_0000;
      trcal_out = 32'h1111_2222;
      capture_dr = 1'b1;
      update_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      update_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL collision_req got 0 exp 1"); end
      n_checks++; if (reg_we !== 1'b1) begin n_fail++; $display("[TB] FAIL collision_we got %b exp 1", reg_we); end
      n_checks++; if (reg_wdata !== 32'h1111_2222) begin n_fail++; $display("[TB] FAIL collision_wdata got %h exp 11112222", reg_wdata); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL collision_overrun got %b exp 1", overrun); end
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit seen;
      tcr = 32'h0200_0000;
      capture_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL midrst_req got 0 exp 1"); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({reg_req, busy, reg_we} !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_ctrl got %b exp 000", {reg_req, busy, reg_we}); end
      n_checks++; if (reg_addr !== 8'h0) begin n_fail++; $display("[TB] FAIL midrst_addr got %h exp 0", reg_addr); end
      n_checks++; if (trcal_in !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_trcal got %h exp 0", trcal_in); end
      n_checks++; if ({timeout, overrun} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_flags got %b exp 00", {timeout, overrun}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_idle got %b exp 0", busy); end
      tcr = 32'h0400_0000;
      capture_dr = 1'b1;
      wait_req(seen);
      capture_dr = 1'b0;
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL postrst_req got 0 exp 1"); end
      n_checks++; if (reg_addr !== 8'h04) begin n_fail++; $display("[TB] FAIL postrst_addr got %h exp 04", reg_addr); end
      reg_rdata = 32'h0BAD_F00D;
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      n_checks++; if (trcal_in !== 32'h0BAD_F00D) begin n_fail++; $display("[TB] FAIL postrst_data got %h exp 0badf00d", trcal_in); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL postrst_busy got %b exp 0", busy); end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      capture_dr = 1'b0;
      update_dr  = 1'b0;
      extest_sel = 1'b0;
      tcr        = 32'h0;
      trcal_out  = 32'h0;
      reg_rdata  = 32'h0;
      reg_ack    = 1'b0;
      clr_flags  = 1'b0;

      test_reset();
      test_read();
      test_write();
      test_debug();
      test_overrun();
      test_timeout();
      test_extest_off();
      test_collision();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
